// File: rtl/gesture_pkg.sv
// Shared types and helpers for the gesture decision filter.
package gesture_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } gesture_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TRACK    = 2'd1,
        S_EMIT     = 2'd2,
        S_COOLDOWN = 2'd3
    } filt_state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/gesture_ms_timer.sv
// Loadable down-counter shared by gap and cooldown timing; expired while count is zero.
// Latency: load takes effect on the next clock; count then falls by one per clock.
// Backpressure: none, free-running once loaded.
module gesture_ms_timer #(
    parameter int unsigned MAX_CYC = 1000,
    parameter int unsigned W       = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/gesture_decision_filter.sv
// Debounces classifier output: emits one gesture after AGREE_COUNT agreeing confident decisions, then cools down.
// Latency: gesture_valid pulses 1 clk after the completing strobe. Optional GESTURE_FILTER_STATS_EN adds counters.
// Backpressure: none; strobes arriving in EMIT/COOLDOWN are dropped.
module gesture_decision_filter
    import gesture_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12_000_000,
    parameter int unsigned CONF_THRESH = 96,
    parameter int unsigned AGREE_COUNT = 3,
    parameter int unsigned GAP_MS      = 500,
    parameter int unsigned COOLDOWN_MS = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] raw_class,
    input  logic [7:0] raw_confidence,
    input  logic       raw_valid,
    output logic [1:0] gesture_class,
    output logic       gesture_valid,
    output logic [7:0] gesture_confidence,
    output logic       busy
`ifdef GESTURE_FILTER_STATS_EN
    ,
    output logic [15:0] emit_count,
    output logic [15:0] drop_count
`endif
);

    localparam int unsigned GAP_CYC = ms_to_cycles(CLK_FREQ_HZ, GAP_MS);
    localparam int unsigned CD_CYC  = ms_to_cycles(CLK_FREQ_HZ, COOLDOWN_MS);
    localparam int unsigned TMAX    = (GAP_CYC > CD_CYC) ? GAP_CYC : CD_CYC;
    localparam int unsigned TW      = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
    localparam logic [7:0]  THRESH  = 8'(CONF_THRESH);
    localparam logic [3:0]  AGREE   = 4'(AGREE_COUNT);

    filt_state_t    state;
    gesture_t       cand;
    logic [3:0]     cnt;
    logic [7:0]     minc;
    logic           qual;
    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic           tmr_expired;
    logic [3:0]     cnt_inc;
    logic [7:0]     min_next;

    assign qual     = raw_valid && (raw_confidence >= THRESH);
    assign cnt_inc  = cnt + 4'd1;
    assign min_next = (raw_confidence < minc) ? raw_confidence : minc;
    assign busy     = (state != S_IDLE);

    // Gap and cooldown never overlap, so one timer serves both.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TW'(GAP_CYC);
        case (state)
            S_IDLE, S_TRACK: tmr_load = qual;
            S_EMIT: begin
                tmr_load = (CD_CYC != 0);
                tmr_val  = TW'(CD_CYC);
            end
            default: tmr_load = 1'b0;
        endcase
    end

    gesture_ms_timer #(
        .MAX_CYC (TMAX),
        .W       (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            cand               <= UP;
            cnt                <= '0;
            minc               <= '0;
            gesture_class      <= '0;
            gesture_valid      <= 1'b0;
            gesture_confidence <= '0;
        end else begin
            gesture_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (qual) begin
                        cand <= gesture_t'(raw_class);
                        cnt  <= 4'd1;
                        minc <= raw_confidence;
                        if (AGREE == 4'd1) begin
                            state              <= S_EMIT;
                            gesture_valid      <= 1'b1;
                            gesture_class      <= raw_class;
                            gesture_confidence <= raw_confidence;
                        end else begin
                            state <= S_TRACK;
                        end
                    end
                end
                S_TRACK: begin
                    if (qual && (raw_class == cand)) begin
                        cnt  <= cnt_inc;
                        minc <= min_next;
                        if (cnt_inc == AGREE) begin
                            state              <= S_EMIT;
                            gesture_valid      <= 1'b1;
                            gesture_class      <= cand;
                            gesture_confidence <= min_next;
                        end
                    end else if (qual) begin
                        cand <= gesture_t'(raw_class);
                        cnt  <= 4'd1;
                        minc <= raw_confidence;
                    end else if (raw_valid || tmr_expired) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                S_EMIT: begin
                    cnt   <= '0;
                    state <= (CD_CYC != 0) ? S_COOLDOWN : S_IDLE;
                end
                default: begin
                    if (tmr_expired) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef GESTURE_FILTER_STATS_EN
    logic drop_ev;
    assign drop_ev = raw_valid &&
                     ((state == S_EMIT) || (state == S_COOLDOWN) || (raw_confidence < THRESH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_count <= '0;
            drop_count <= '0;
        end else begin
            if (gesture_valid && (emit_count != 16'hFFFF)) begin
                emit_count <= emit_count + 16'd1;
            end
            if (drop_ev && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule
